// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 LSB first on one pin.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1). Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic [DIV_W-1:0]         clkdiv,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic push_en;
  logic pop_en;
  logic bit_done;

  // Readiness depends only on registered level, so a same-cycle pop never frees a slot.
  assign din_ready  = (level_q != LVL_W'(DEPTH));
  assign push_en    = din_valid && din_ready;
  assign pop_en     = (state_q == S_IDLE) && (level_q != '0);
  assign bit_done   = (cnt_q == '0);
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (level_q != '0);
  assign fifo_level = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    period_d = period_q;
    tx_d     = tx_q;
    cnt_d    = bit_done ? (period_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    // tx_d always carries the level of the state being entered, keeping tx a pure flop.
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = cnt_q;
        if (pop_en) begin
          shift_d  = mem_q[rd_ptr_q];
          period_d = (clkdiv < DIV_W'(2)) ? DIV_W'(1) : clkdiv;
          cnt_d    = period_d - DIV_W'(1);
          tx_d     = 1'b0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      period_q <= DIV_W'(1);
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage needs no reset: the level counter alone says which entries are live.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- User-project UART transmitter: firmware or user logic pushes bytes through a valid/ready port into a small FIFO.
- Serialises each byte as 8N1, LSB first, on one mprj_io pin.
- It is the transmit counterpart of the testbench UART receiver that monitors mprj_io[6].
- Sits in the user project area, clocked by the Caravel core clock.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- resetb  input  1  asynchronous, active-low reset.
- clkdiv  input  DIV_W  clocks per bit; values 0 and 1 are treated as 1.
- din  input  8  byte to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  FIFO can accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress, or FIFO not empty.
- fifo_level  output  $clog2(DEPTH)+1  number of bytes currently held in the FIFO.

Behaviour:
- Reset (resetb low, asynchronous):
  - tx=1, din_ready=1, busy=0, fifo_level=0.
  - FSM forced to IDLE, FIFO pointers cleared, bit and baud counters cleared.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
- FIFO:
  - Push on the clock edge where din_valid && din_ready.
  - din_ready = (fifo_level != DEPTH), registered state only.
  - A pop in the same cycle does not open space for a push at full; that push is refused.
  - Pointers wrap modulo DEPTH.
  - Push while FIFO is empty: the byte is visible to the FSM on the next edge.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO not empty, pop one byte into the shift register, latch clkdiv (min 1) into the period register, go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for one bit period, shift right, index+1. After index 7, go to PARITY if enabled, else STOP.
  - PARITY: tx=even parity of the byte for one bit period (feature only), then go to STOP.
  - STOP: tx=1 for one bit period, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty, so the gap between stop bit end and next start bit is 1 clock.
- Baud counter:
  - Counts from period-1 down to 0; the state advances on the cycle the count is 0.
  - clkdiv changes mid-frame are ignored until the next pop.
- Latency: byte accepted on edge N → tx falls after edge N+1 when idle with an empty FIFO.
- busy = (state != IDLE) || (fifo_level != 0); it falls on the edge that enters IDLE with an empty FIFO.
- tx is driven from a flop; no combinational path from any input to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state compiled in; frame is 8E1, 11 bit periods total. Parity bit = XOR of the 8 data bits.
- Undefined: no PARITY state or logic; frame is 8N1, 10 bit periods.

Test Plan:
- Reset then idle, no pushes, 100 cycles → tx=1, busy=0, din_ready=1, fifo_level=0 throughout.
- clkdiv=4, push 8'hA5 → tx after edge N+1: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each bit is exactly 4 clocks; frame is 40 clocks (44 with UART_TX_PARITY_EN, parity bit 0).
- clkdiv=2, DEPTH=4, hold din_valid with 8'h01..8'h06 → first 5 accepted: one popped immediately, FIFO then fills to 4. din_ready=0 until the next pop. Bytes appear in order with a 1-clock gap between frames.
- Push at full while the FSM pops in the same cycle → push refused (din_ready was 0); the byte is accepted on the following cycle and its transmission order is preserved.
- clkdiv changed 4→8 mid-frame → current frame stays at 4 clocks per bit; the next frame runs at 8 clocks per bit.
- Assert resetb low during data bit 3 of 8'h3C → tx=1 and fifo_level=0 immediately. After release, push 8'h55 → correct frame, no remnant of 8'h3C.
